// File: rtl/pc_fetch_unit.sv
// ------------------------------------------------------------------------------------------------
// pc_fetch_unit
//
// Holds the fetch PC, fetches one instruction at a time from instruction memory over a
// req/gnt/rvalid handshake and presents it to decode over a valid/ready handshake. The next-PC
// logic sits outside this block: it sees pc_out and returns npc_in, which is loaded only when
// decode accepts the instruction. All addresses are 30-bit word addresses.
//
// Ports
//   clk          in   1   single clock, rising edge
//   reset        in   1   asynchronous, active-high; clears all state
//   npc_in       in   30  next PC, sampled only on a decode accept
//   flush        in   1   discard in-flight/held instruction, redirect fetch to flush_pc
//   flush_pc     in   30  redirect target, sampled when flush=1
//   imem_req     out  1   memory request
//   imem_addr    out  30  request word address
//   imem_gnt     in   1   memory accepts the request this cycle
//   imem_rvalid  in   1   read data valid
//   imem_rdata   in   32  instruction word
//   instr_valid  out  1   instr/pc_out hold a valid instruction
//   instr_ready  in   1   decode accepts this cycle
//   instr        out  32  instruction word
//   pc_out       out  30  word address of instr
//   instr_cnt    out  32  accepted-instruction count, wraps to 0
//   proto_err    out  1   sticky: imem_rvalid seen while no request was outstanding
// ------------------------------------------------------------------------------------------------
module pc_fetch_unit #(
    parameter logic [29:0] RESET_PC = 30'h0000_0C00
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [29:0] npc_in,
    input  logic        flush,
    input  logic [29:0] flush_pc,
    output logic        imem_req,
    output logic [29:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr,
    output logic [29:0] pc_out,
    output logic [31:0] instr_cnt,
    output logic        proto_err
);

    // StReq : request outstanding towards memory at fetch_pc
    // StWait: granted, waiting for the single rvalid
    // StHold: instruction presented to decode
    typedef enum logic [1:0] {
        StReq  = 2'd0,
        StWait = 2'd1,
        StHold = 2'd2
    } state_e;

    state_e      state_q,       state_d;
    logic [29:0] fetch_pc_q,    fetch_pc_d;
    logic        drop_q,        drop_d;
    logic [31:0] instr_q,       instr_d;
    logic [29:0] pc_out_q,      pc_out_d;
    logic        instr_valid_q, instr_valid_d;
    logic [31:0] instr_cnt_q,   instr_cnt_d;
    logic        proto_err_q,   proto_err_d;

    // --------------------------------------------------------------------------------------------
    // State registers
    // --------------------------------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= StReq;
            fetch_pc_q    <= RESET_PC;
            drop_q        <= 1'b0;
            instr_q       <= 32'h0;
            pc_out_q      <= 30'h0;
            instr_valid_q <= 1'b0;
            instr_cnt_q   <= 32'h0;
            proto_err_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            fetch_pc_q    <= fetch_pc_d;
            drop_q        <= drop_d;
            instr_q       <= instr_d;
            pc_out_q      <= pc_out_d;
            instr_valid_q <= instr_valid_d;
            instr_cnt_q   <= instr_cnt_d;
            proto_err_q   <= proto_err_d;
        end
    end

    // --------------------------------------------------------------------------------------------
    // Next-state logic. Flush is evaluated first in every state so it wins over gnt, rvalid and
    // ready arriving in the same cycle.
    // --------------------------------------------------------------------------------------------
    always_comb begin
        state_d       = state_q;
        fetch_pc_d    = fetch_pc_q;
        drop_d        = drop_q;
        instr_d       = instr_q;
        pc_out_d      = pc_out_q;
        instr_valid_d = instr_valid_q;
        instr_cnt_d   = instr_cnt_q;
        proto_err_d   = proto_err_q;

        // Only StWait has a request outstanding; any other rvalid is a memory protocol
        // violation. The data is ignored and the flag stays set until reset.
        if (imem_rvalid && (state_q != StWait)) begin
            proto_err_d = 1'b1;
        end

        unique case (state_q)
            StReq: begin
                if (flush) begin
                    fetch_pc_d = flush_pc;
                    // The granted request still targets the old PC; its response must be
                    // swallowed before refetching at flush_pc.
                    if (imem_gnt) begin
                        drop_d  = 1'b1;
                        state_d = StWait;
                    end
                end else if (imem_gnt) begin
                    state_d = StWait;
                end
            end

            StWait: begin
                if (flush) begin
                    fetch_pc_d = flush_pc;
                    if (imem_rvalid) begin
                        drop_d  = 1'b0;
                        state_d = StReq;
                    end else begin
                        drop_d = 1'b1;
                    end
                end else if (imem_rvalid) begin
                    if (drop_q) begin
                        drop_d  = 1'b0;
                        state_d = StReq;
                    end else begin
                        // Registered capture: decode never sees rdata combinationally.
                        instr_d       = imem_rdata;
                        pc_out_d      = fetch_pc_q;
                        instr_valid_d = 1'b1;
                        state_d       = StHold;
                    end
                end
            end

            StHold: begin
                if (flush) begin
                    // A same-cycle ready is not an accept: no count, npc_in ignored.
                    instr_valid_d = 1'b0;
                    fetch_pc_d    = flush_pc;
                    state_d       = StReq;
                end else if (instr_ready) begin
                    fetch_pc_d    = npc_in;
                    instr_valid_d = 1'b0;
                    instr_cnt_d   = instr_cnt_q + 32'd1;
                    state_d       = StReq;
                end
            end

            default: begin
                state_d = StReq;
            end
        endcase
    end

    // --------------------------------------------------------------------------------------------
    // Outputs. The request is masked while reset is held so no request is issued in the reset
    // cycle even though the state register already reads StReq.
    // --------------------------------------------------------------------------------------------
    assign imem_req    = (state_q == StReq) && !reset;
    assign imem_addr   = fetch_pc_q;
    assign instr_valid = instr_valid_q;
    assign instr       = instr_q;
    assign pc_out      = pc_out_q;
    assign instr_cnt   = instr_cnt_q;
    assign proto_err   = proto_err_q;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// ------------------------------------------------------------------------------------------------
// tb_pc_fetch_unit
//
// Directed bench for pc_fetch_unit. A memory responder grants requests after a programmable
// delay and returns {2'b10, addr} as the instruction word a programmable number of cycles later.
// A transaction-level model tracks "is a request outstanding", "is its answer to be dropped" and
// "is an instruction held for decode" and is compared against every DUT output every cycle.
// Literal expectations at each scenario pin the model.
// ------------------------------------------------------------------------------------------------
module tb_pc_fetch_unit;

    localparam logic [29:0] RESET_PC = 30'h0000_0C00;

    logic        clk = 1'b0;
    logic        reset;
    logic [29:0] npc_in;
    logic        flush;
    logic [29:0] flush_pc;
    logic        imem_req;
    logic [29:0] imem_addr;
    logic        imem_gnt    = 1'b0;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata  = 32'h0;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [29:0] pc_out;
    logic [31:0] instr_cnt;
    logic        proto_err;

    pc_fetch_unit #(
        .RESET_PC(RESET_PC)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .npc_in     (npc_in),
        .flush      (flush),
        .flush_pc   (flush_pc),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_gnt   (imem_gnt),
        .imem_rvalid(imem_rvalid),
        .imem_rdata (imem_rdata),
        .instr_valid(instr_valid),
        .instr_ready(instr_ready),
        .instr      (instr),
        .pc_out     (pc_out),
        .instr_cnt  (instr_cnt),
        .proto_err  (proto_err)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [29:0] a);
        return {2'b10, a};
    endfunction

    // --------------------------------------------------------------------------------------------
    // Memory responder (knobs written by the main process only)
    // --------------------------------------------------------------------------------------------
    int          gnt_lat = 0;
    int          rv_lat  = 1;
    logic        dead    = 1'b0;
    int          inj_req = 0;
    int          inj_done = 0;
    logic        rv_pend = 1'b0;
    int          rv_wait = 0;
    logic [29:0] rv_addr = 30'h0;
    int          req_age = 0;

    always @(posedge clk) begin
        logic        hs;
        logic [29:0] a;
        hs = imem_req && imem_gnt;
        a  = imem_addr;
        #1;
        imem_rvalid = 1'b0;
        imem_rdata  = 32'h0;
        if (hs) begin
            rv_pend = 1'b1;
            rv_wait = rv_lat - 1;
            rv_addr = a;
        end
        if (rv_pend) begin
            if (rv_wait <= 0) begin
                imem_rvalid = 1'b1;
                imem_rdata  = dead ? 32'hDEAD_BEEF : mem_word(rv_addr);
                rv_pend     = 1'b0;
            end else begin
                rv_wait--;
            end
        end else if (inj_req != inj_done) begin
            imem_rvalid = 1'b1;
            imem_rdata  = 32'h5555_AAAA;
            inj_done++;
        end
        if (imem_req) begin
            imem_gnt = (req_age >= gnt_lat);
            req_age++;
        end else begin
            imem_gnt = 1'b0;
            req_age  = 0;
        end
    end

    // --------------------------------------------------------------------------------------------
    // Checking
    // --------------------------------------------------------------------------------------------
    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Transaction-level model
    logic        m_out, m_drop, m_hold, m_perr;
    logic [29:0] m_pc, m_pcout, m_gaddr;
    logic [31:0] m_instr, m_cnt;

    task automatic model_reset();
        m_out   = 1'b0;
        m_drop  = 1'b0;
        m_hold  = 1'b0;
        m_perr  = 1'b0;
        m_pc    = RESET_PC;
        m_pcout = 30'h0;
        m_gaddr = 30'h0;
        m_instr = 32'h0;
        m_cnt   = 32'h0;
    endtask

    // Called right at the rising edge with the values the DUT samples there.
    task automatic model_step();
        logic can_req;
        if (reset) begin
            model_reset();
            return;
        end
        can_req = !m_out && !m_hold;
        if (imem_rvalid && !m_out) m_perr = 1'b1;
        if (flush) begin
            if (m_hold) begin
                m_hold = 1'b0;
            end else if (can_req && imem_gnt) begin
                m_out  = 1'b1;
                m_drop = 1'b1;
            end else if (m_out) begin
                if (imem_rvalid) begin
                    m_out  = 1'b0;
                    m_drop = 1'b0;
                end else begin
                    m_drop = 1'b1;
                end
            end
            m_pc = flush_pc;
        end else if (m_hold && instr_ready) begin
            m_hold = 1'b0;
            m_cnt  = m_cnt + 32'd1;
            m_pc   = npc_in;
        end else if (can_req && imem_gnt) begin
            m_out   = 1'b1;
            m_gaddr = m_pc;
        end else if (m_out && imem_rvalid) begin
            m_out = 1'b0;
            if (m_drop) begin
                m_drop = 1'b0;
            end else begin
                m_hold  = 1'b1;
                m_instr = imem_rdata;
                m_pcout = m_gaddr;
            end
        end
    endtask

    task automatic check_model();
        logic exp_req;
        exp_req = !reset && !m_out && !m_hold;
        chk("model imem_req", imem_req, exp_req);
        if (exp_req) chk("model imem_addr", imem_addr, m_pc);
        chk("model instr_valid", instr_valid, m_hold);
        chk("model instr", instr, m_instr);
        chk("model pc_out", pc_out, m_pcout);
        chk("model instr_cnt", instr_cnt, m_cnt);
        chk("model proto_err", proto_err, m_perr);
    endtask

    int cyc = 0;

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        cyc++;
        check_model();
    endtask

    task automatic wait_valid(input int max_cyc, input string nm);
        logic ok;
        ok = 1'b0;
        for (int i = 0; i < max_cyc; i++) begin
            if (instr_valid) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        if (!ok) ok = instr_valid;
        chk(nm, ok, 1'b1);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        model_reset();
        tick();
        tick();
        reset = 1'b0;
    endtask

    // --------------------------------------------------------------------------------------------
    // Stimulus
    // --------------------------------------------------------------------------------------------
    logic [29:0] gq[$];
    int          vq[$];

    initial begin
        npc_in      = 30'h0;
        flush       = 1'b0;
        flush_pc    = 30'h0;
        instr_ready = 1'b0;
        reset       = 1'b1;
        model_reset();
        @(negedge clk);
        #1;
        chk("reset imem_req", imem_req, 1'b0);
        chk("reset instr_valid", instr_valid, 1'b0);
        chk("reset instr_cnt", instr_cnt, 32'h0);
        chk("reset imem_addr", imem_addr, 30'h0000_0C00);
        do_reset();

        // 1: back-to-back fetch, gnt at once, rvalid one cycle later, ready always high
        gnt_lat     = 0;
        rv_lat      = 1;
        instr_ready = 1'b1;
        for (int i = 0; i < 40; i++) begin
            if (instr_cnt == 32'd3) break;
            npc_in = pc_out + 30'd1;
            tick();
            if (imem_req && imem_gnt) gq.push_back(imem_addr);
            if (instr_valid) vq.push_back(cyc);
        end
        chk("s1 instr_cnt", instr_cnt, 32'd3);
        chk("s1 addr0", gq.size() > 0 ? gq[0] : 30'h0, 30'h0000_0C00);
        chk("s1 addr1", gq.size() > 1 ? gq[1] : 30'h0, 30'h0000_0C01);
        chk("s1 addr2", gq.size() > 2 ? gq[2] : 30'h0, 30'h0000_0C02);
        chk("s1 valid spacing a", vq.size() > 2 ? vq[1] - vq[0] : 0, 32'd3);
        chk("s1 valid spacing b", vq.size() > 2 ? vq[2] - vq[1] : 0, 32'd3);

        // 2: decode stalls for 5 cycles, then accepts with a jump to 0x1000
        instr_ready = 1'b0;
        wait_valid(10, "s2 wait valid");
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("s2 instr stable", instr, 32'h8000_0C03);
            chk("s2 pc_out stable", pc_out, 30'h0000_0C03);
            chk("s2 no req", imem_req, 1'b0);
        end
        instr_ready = 1'b1;
        npc_in      = 30'h0000_1000;
        tick();
        instr_ready = 1'b0;
        chk("s2 req after accept", imem_req, 1'b1);
        chk("s2 jump addr", imem_addr, 30'h0000_1000);
        wait_valid(10, "s2 drain");

        // 3: slow memory, gnt after 4 cycles of req, rvalid 3 cycles after gnt
        gnt_lat = 4;
        rv_lat  = 3;
        do_reset();
        for (int i = 0; i < 20; i++) begin
            if (instr_valid) break;
            if (imem_req) chk("s3 addr held", imem_addr, 30'h0000_0C00);
            tick();
        end
        chk("s3 valid", instr_valid, 1'b1);
        chk("s3 instr", instr, 32'h8000_0C00);
        chk("s3 pc_out", pc_out, 30'h0000_0C00);

        // 4: flush while waiting for data; the returned word must be dropped
        gnt_lat     = 0;
        instr_ready = 1'b1;
        npc_in      = 30'h0000_0C01;
        tick();
        instr_ready = 1'b0;
        tick();
        chk("s4 in wait", imem_req, 1'b0);
        flush    = 1'b1;
        flush_pc = 30'h0000_2000;
        dead     = 1'b1;
        tick();
        flush = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (imem_req) break;
            chk("s4 no valid", instr_valid, 1'b0);
            tick();
        end
        chk("s4 refetch", imem_req, 1'b1);
        chk("s4 refetch addr", imem_addr, 30'h0000_2000);
        dead = 1'b0;

        // 5: flush and ready together in hold
        wait_valid(10, "s5 wait valid");
        chk("s5 pc_out", pc_out, 30'h0000_2000);
        chk("s5 instr", instr, 32'h8000_2000);
        instr_ready = 1'b1;
        flush       = 1'b1;
        flush_pc    = 30'h0000_3000;
        npc_in      = 30'h0000_2001;
        tick();
        flush       = 1'b0;
        instr_ready = 1'b0;
        chk("s5 cnt unchanged", instr_cnt, 32'd1);
        chk("s5 valid cleared", instr_valid, 1'b0);
        chk("s5 req", imem_req, 1'b1);
        chk("s5 flush addr", imem_addr, 30'h0000_3000);

        // 6: stray rvalid in hold, then reset in the middle of a transaction
        wait_valid(10, "s6 wait valid");
        inj_req++;
        tick();
        tick();
        chk("s6 proto_err", proto_err, 1'b1);
        chk("s6 instr kept", instr, 32'h8000_3000);
        chk("s6 still valid", instr_valid, 1'b1);
        instr_ready = 1'b1;
        npc_in      = 30'h0000_3001;
        tick();
        instr_ready = 1'b0;
        tick();
        chk("s6 in wait", imem_req, 1'b0);
        reset = 1'b1;
        model_reset();
        #1;
        chk("s6 rst req", imem_req, 1'b0);
        chk("s6 rst valid", instr_valid, 1'b0);
        chk("s6 rst instr", instr, 32'h0);
        chk("s6 rst pc_out", pc_out, 30'h0);
        chk("s6 rst cnt", instr_cnt, 32'h0);
        chk("s6 rst proto_err", proto_err, 1'b0);
        tick();
        reset = 1'b0;
        tick();
        chk("s6 first req", imem_req, 1'b1);
        chk("s6 first addr", imem_addr, 30'h0000_0C00);
        tick();
        chk("s6 late rvalid", proto_err, 1'b1);
        for (int i = 0; i < 6; i++) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
